// File: rtl/cdb_arbiter_if.sv
// Result-bus interface between the execution units, the CDB arbiter and the
// snooping consumers (RS, LSB, ROB).
//
// Handshake: alu_result / lsb_result are one-cycle valid pulses. The matching
// *_stall output is the only back-pressure: while it is high the producer
// holds new results. One queue slot stays free for a result already in
// flight. cdb_en marks a valid broadcast. Consumers take every broadcast and
// cannot stall the bus.
interface cdb_arbiter_if #(
  parameter int DATA_W    = 32,
  parameter int ROB_POS_W = 4
);
  logic                 rdy;
  logic                 rollback;
  logic                 alu_result;
  logic [DATA_W-1:0]    alu_result_val;
  logic [ROB_POS_W-1:0] alu_result_rob_pos;
  logic                 lsb_result;
  logic [DATA_W-1:0]    lsb_result_val;
  logic [ROB_POS_W-1:0] lsb_result_rob_pos;
  logic                 alu_stall;
  logic                 lsb_stall;
  logic                 cdb_en;
  logic [DATA_W-1:0]    cdb_val;
  logic [ROB_POS_W-1:0] cdb_rob_pos;
  logic                 cdb_src;
  logic                 overflow;

  // Environment side: producers plus global control, consumers of the bus.
  modport master (
    output rdy, rollback,
    output alu_result, alu_result_val, alu_result_rob_pos,
    output lsb_result, lsb_result_val, lsb_result_rob_pos,
    input  alu_stall, lsb_stall, cdb_en, cdb_val, cdb_rob_pos, cdb_src, overflow
  );

  // Arbiter side.
  modport slave (
    input  rdy, rollback,
    input  alu_result, alu_result_val, alu_result_rob_pos,
    input  lsb_result, lsb_result_val, lsb_result_rob_pos,
    output alu_stall, lsb_stall, cdb_en, cdb_val, cdb_rob_pos, cdb_src, overflow
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: two small result queues (ALU, LSB) with empty-queue bypass,
// round-robin grant on conflict, and a registered broadcast bus.
module cdb_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ROB_POS_W = 4,
  parameter int DEPTH     = 4
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [DATA_W-1:0]    val;
    logic [ROB_POS_W-1:0] pos;
  } entry_t;

  entry_t           alu_q [DEPTH];
  entry_t           lsb_q [DEPTH];
  logic [PTR_W-1:0] alu_head, alu_tail, lsb_head, lsb_tail;
  logic [CNT_W-1:0] alu_cnt, lsb_cnt;
  logic             last_grant;  // 0 = ALU, 1 = LSB

  logic                 cdb_en_r, cdb_src_r, overflow_r;
  logic [DATA_W-1:0]    cdb_val_r;
  logic [ROB_POS_W-1:0] cdb_pos_r;

  entry_t alu_in, lsb_in, alu_cand, lsb_cand, win;
  logic   alu_has_q, lsb_has_q, alu_cand_v, lsb_cand_v;
  logic   grant_alu, grant_lsb;
  logic   alu_pop, lsb_pop, alu_bypass, lsb_bypass;
  logic   alu_push_req, lsb_push_req, alu_push, lsb_push, alu_drop, lsb_drop;

  assign alu_in = {bus.alu_result_val, bus.alu_result_rob_pos};
  assign lsb_in = {bus.lsb_result_val, bus.lsb_result_rob_pos};

  // Candidate selection, round-robin grant and queue push/pop decisions.
  always_comb begin
    alu_has_q  = (alu_cnt != '0);
    lsb_has_q  = (lsb_cnt != '0);
    alu_cand_v = alu_has_q | bus.alu_result;
    lsb_cand_v = lsb_has_q | bus.lsb_result;
    alu_cand   = alu_has_q ? alu_q[alu_head] : alu_in;
    lsb_cand   = lsb_has_q ? lsb_q[lsb_head] : lsb_in;
    // On a tie the source that did not win last time goes first.
    grant_alu  = alu_cand_v & (~lsb_cand_v | last_grant);
    grant_lsb  = lsb_cand_v & ~grant_alu;
    win        = grant_lsb ? lsb_cand : alu_cand;
    alu_pop    = grant_alu & alu_has_q;
    lsb_pop    = grant_lsb & lsb_has_q;
    alu_bypass = grant_alu & ~alu_has_q;
    lsb_bypass = grant_lsb & ~lsb_has_q;
    alu_push_req = bus.alu_result & ~alu_bypass;
    lsb_push_req = bus.lsb_result & ~lsb_bypass;
    // A full queue still accepts a push when its head leaves on the same edge.
    alu_drop   = alu_push_req & (alu_cnt == CNT_W'(DEPTH)) & ~alu_pop;
    lsb_drop   = lsb_push_req & (lsb_cnt == CNT_W'(DEPTH)) & ~lsb_pop;
    alu_push   = alu_push_req & ~alu_drop;
    lsb_push   = lsb_push_req & ~lsb_drop;
  end

  // Queue storage; occupancy is tracked by the counters, so no reset needed.
  always_ff @(posedge clk) begin
    if (bus.rdy && !bus.rollback) begin
      if (alu_push) alu_q[alu_tail] <= alu_in;
      if (lsb_push) lsb_q[lsb_tail] <= lsb_in;
    end
  end

  // Queue pointers/counts, grant history, broadcast registers, sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_head   <= '0;
      alu_tail   <= '0;
      alu_cnt    <= '0;
      lsb_head   <= '0;
      lsb_tail   <= '0;
      lsb_cnt    <= '0;
      last_grant <= 1'b1;
      cdb_en_r   <= 1'b0;
      cdb_val_r  <= '0;
      cdb_pos_r  <= '0;
      cdb_src_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else if (bus.rdy) begin
      if (bus.rollback) begin
        alu_head   <= '0;
        alu_tail   <= '0;
        alu_cnt    <= '0;
        lsb_head   <= '0;
        lsb_tail   <= '0;
        lsb_cnt    <= '0;
        last_grant <= 1'b1;
        cdb_en_r   <= 1'b0;
      end else begin
        if (alu_pop)  alu_head <= alu_head + PTR_W'(1);
        if (alu_push) alu_tail <= alu_tail + PTR_W'(1);
        if (lsb_pop)  lsb_head <= lsb_head + PTR_W'(1);
        if (lsb_push) lsb_tail <= lsb_tail + PTR_W'(1);
        alu_cnt <= alu_cnt + CNT_W'(alu_push) - CNT_W'(alu_pop);
        lsb_cnt <= lsb_cnt + CNT_W'(lsb_push) - CNT_W'(lsb_pop);
        if (grant_alu || grant_lsb) begin
          cdb_en_r   <= 1'b1;
          cdb_val_r  <= win.val;
          cdb_pos_r  <= win.pos;
          cdb_src_r  <= grant_lsb;
          last_grant <= grant_lsb;
        end else begin
          cdb_en_r   <= 1'b0;
        end
        if (alu_drop || lsb_drop) overflow_r <= 1'b1;
      end
    end
  end

  assign bus.alu_stall   = (alu_cnt >= CNT_W'(DEPTH - 1));
  assign bus.lsb_stall   = (lsb_cnt >= CNT_W'(DEPTH - 1));
  assign bus.cdb_en      = cdb_en_r;
  assign bus.cdb_val     = cdb_val_r;
  assign bus.cdb_rob_pos = cdb_pos_r;
  assign bus.cdb_src     = cdb_src_r;
  assign bus.overflow    = overflow_r;
endmodule
